// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner arbitration for a shared N:1 bit mux.
// Each requester owns one mux input. The scheduler selects the owner through addr and
// registers the mux output so that the owner sees a cycle-aligned data bit.
module mux_rr_sched #(
  parameter int unsigned N_REQ    = 7,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  input  logic              res_in,
  output logic [ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]  gnt,
  output logic              gnt_valid,
  output logic              data_out,
  output logic              data_valid
);

  // hold_cnt needs at least one bit, even when MAX_HOLD is 1
  localparam int unsigned       HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  // The pointer starts at the last requester, so the first search begins at requester 0
  localparam logic [ADDR_W-1:0] PTR_INIT  = ADDR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  state_e             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [ADDR_W-1:0]  ptr;

  logic               win_found;
  logic [ADDR_W-1:0]  win_idx;
  logic [N_REQ-1:0]   win_oh;

  logic               own_done;
  logic               own_drop;
  logic               hold_last;
  logic               grant_exit;

  // Winner search: first set req bit strictly after ptr, then wrap to 0..ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (ADDR_W'(i) > ptr)) begin
        win_found = 1'b1;
        win_idx   = ADDR_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (ADDR_W'(i) <= ptr)) begin
        win_found = 1'b1;
        win_idx   = ADDR_W'(i);
      end
    end
    win_oh = N_REQ'(1) << win_idx;
  end

  // Release conditions look only at the owner's bits; gnt is one-hot while granting
  always_comb begin
    own_done   = |(done & gnt);
    own_drop   = ~|(req & gnt);
    hold_last  = (hold_cnt == HOLD_LAST);
    grant_exit = own_done | own_drop | hold_last;
  end

  // Scheduler FSM with registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      addr      <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= PTR_INIT;
    end else begin
      unique case (state)
        StIdle: begin
          if (win_found) begin
            state     <= StGrant;
            addr      <= win_idx;
            gnt       <= win_oh;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        StGrant: begin
          if (grant_exit) begin
            state     <= StRelease;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= addr;
            hold_cnt  <= '0;
          end else begin
            hold_cnt  <= hold_cnt + HOLD_W'(1);
          end
        end
        StRelease: begin
          // addr keeps the last owner, so the mux input stays stable during the gap
          state <= StIdle;
        end
        default: begin
          state     <= StIdle;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sample the mux output while a grant is active; data_valid follows gnt_valid by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      if (gnt_valid) begin
        data_out <= res_in;
      end
      data_valid <= gnt_valid;
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: directed phases followed by random traffic, checked each cycle
// against a transaction-level model of owner, grant length and sampled data.
module tb_mux_rr_sched;

  localparam int N_REQ    = 7;
  localparam int MAX_HOLD = 4;
  localparam int NCYC     = 2500;

  logic       clk;
  logic       rst;
  logic [6:0] req;
  logic [6:0] done;
  logic       res_in;
  logic [2:0] addr;
  logic [6:0] gnt;
  logic       gnt_valid;
  logic       data_out;
  logic       data_valid;

  // Mux inputs a..g, with a in bit 0
  logic [6:0] mux_in;
  assign res_in = mux_in[addr];

  mux_rr_sched #(
    .N_REQ    (7),
    .ADDR_W   (3),
    .MAX_HOLD (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .res_in     (res_in),
    .addr       (addr),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: owner is -1 when nobody holds the mux
  int         owner;
  int         held;
  int         last;
  bit         in_gap;
  logic [2:0] exp_addr;
  logic [6:0] exp_gnt;
  logic       exp_gv;
  logic       exp_dout;
  logic       exp_dv;

  task automatic model_reset();
    owner    = -1;
    held     = 0;
    last     = N_REQ - 1;
    in_gap   = 1'b0;
    exp_addr = 3'd0;
    exp_gnt  = 7'd0;
    exp_gv   = 1'b0;
    exp_dout = 1'b0;
    exp_dv   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    logic [2:0] o;
    int         idx;
    if (rst) begin
      model_reset();
      return;
    end
    if (exp_gv) exp_dout = mux_in[exp_addr];
    exp_dv = exp_gv;
    if (owner >= 0) begin
      o = 3'(owner);
      held++;
      if (done[o] || !req[o] || held == MAX_HOLD) begin
        last   = owner;
        owner  = -1;
        in_gap = 1'b1;
      end
    end else if (in_gap) begin
      in_gap = 1'b0;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (last + k) % N_REQ;
        o   = 3'(idx);
        if (owner < 0 && req[o]) begin
          owner = idx;
          held  = 0;
        end
      end
    end
    exp_gv = (owner >= 0);
    if (owner >= 0) begin
      exp_addr = 3'(owner);
      exp_gnt  = 7'd1 << owner;
    end else begin
      exp_gnt  = 7'd0;
    end
  endtask

  // Inputs for the cycle that ends at the next posedge
  task automatic drive(input int cyc);
    if (cyc < 3) begin
      rst = 1'b1; req = 7'd0; done = 7'd0; mux_in = 7'b0010011;
    end else if (cyc < 40) begin
      rst = 1'b0; req = 7'b0000100; done = 7'd0;
    end else if (cyc < 90) begin
      rst = 1'b0; req = 7'b0100101; done = 7'd0;
    end else if (cyc < 130) begin
      rst = 1'b0; req = 7'b1000001; done = 7'd0;
      if (cyc >= 110) mux_in = 7'b1010011;
    end else begin
      rst = ($urandom_range(59) == 0);
      if ($urandom_range(3) == 0) req = 7'($urandom);
      done = ($urandom_range(4) == 0) ? 7'($urandom) : 7'd0;
      if ($urandom_range(7) == 0) mux_in = 7'($urandom);
    end
  endtask

  initial begin
    model_reset();
    drive(0);
    for (int cyc = 1; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (cyc >= 2) begin
        check_eq("gnt",        32'(gnt),        32'(exp_gnt));
        check_eq("gnt_valid",  32'(gnt_valid),  32'(exp_gv));
        check_eq("addr",       32'(addr),       32'(exp_addr));
        check_eq("data_out",   32'(data_out),   32'(exp_dout));
        check_eq("data_valid", 32'(data_valid), 32'(exp_dv));
      end
      drive(cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
